// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants, decoder state type and scan-code-set-2 to ASCII
// lookup for the PS/2 keyboard front end.
//   SC_*        : special scan codes (prefixes, modifiers, control keys)
//   dec_state_t : prefix-tracking states of the decoder FSM
//   sc2ascii    : maps a make code to ASCII, 0 when the code is unmapped
package kbd_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  // Letters are looked up lowercase and folded to uppercase afterwards, so
  // 'upper' (Shift XOR Caps) only affects letters while 'shift' alone picks
  // the US shifted glyph for digits and punctuation.
  function automatic logic [7:0] sc2ascii(input logic [7:0] code,
                                          input logic       upper,
                                          input logic       shift);
    logic [7:0] ch;
    logic       is_letter;
    ch        = 8'h00;
    is_letter = 1'b0;
    case (code)
      8'h1C: begin ch = 8'h61; is_letter = 1'b1; end
      8'h32: begin ch = 8'h62; is_letter = 1'b1; end
      8'h21: begin ch = 8'h63; is_letter = 1'b1; end
      8'h23: begin ch = 8'h64; is_letter = 1'b1; end
      8'h24: begin ch = 8'h65; is_letter = 1'b1; end
      8'h2B: begin ch = 8'h66; is_letter = 1'b1; end
      8'h34: begin ch = 8'h67; is_letter = 1'b1; end
      8'h33: begin ch = 8'h68; is_letter = 1'b1; end
      8'h43: begin ch = 8'h69; is_letter = 1'b1; end
      8'h3B: begin ch = 8'h6A; is_letter = 1'b1; end
      8'h42: begin ch = 8'h6B; is_letter = 1'b1; end
      8'h4B: begin ch = 8'h6C; is_letter = 1'b1; end
      8'h3A: begin ch = 8'h6D; is_letter = 1'b1; end
      8'h31: begin ch = 8'h6E; is_letter = 1'b1; end
      8'h44: begin ch = 8'h6F; is_letter = 1'b1; end
      8'h4D: begin ch = 8'h70; is_letter = 1'b1; end
      8'h15: begin ch = 8'h71; is_letter = 1'b1; end
      8'h2D: begin ch = 8'h72; is_letter = 1'b1; end
      8'h1B: begin ch = 8'h73; is_letter = 1'b1; end
      8'h2C: begin ch = 8'h74; is_letter = 1'b1; end
      8'h3C: begin ch = 8'h75; is_letter = 1'b1; end
      8'h2A: begin ch = 8'h76; is_letter = 1'b1; end
      8'h1D: begin ch = 8'h77; is_letter = 1'b1; end
      8'h22: begin ch = 8'h78; is_letter = 1'b1; end
      8'h35: begin ch = 8'h79; is_letter = 1'b1; end
      8'h1A: begin ch = 8'h7A; is_letter = 1'b1; end
      8'h45: ch = shift ? 8'h29 : 8'h30;
      8'h16: ch = shift ? 8'h21 : 8'h31;
      8'h1E: ch = shift ? 8'h40 : 8'h32;
      8'h26: ch = shift ? 8'h23 : 8'h33;
      8'h25: ch = shift ? 8'h24 : 8'h34;
      8'h2E: ch = shift ? 8'h25 : 8'h35;
      8'h36: ch = shift ? 8'h5E : 8'h36;
      8'h3D: ch = shift ? 8'h26 : 8'h37;
      8'h3E: ch = shift ? 8'h2A : 8'h38;
      8'h46: ch = shift ? 8'h28 : 8'h39;
      8'h0E: ch = shift ? 8'h7E : 8'h60;
      8'h4E: ch = shift ? 8'h5F : 8'h2D;
      8'h55: ch = shift ? 8'h2B : 8'h3D;
      8'h54: ch = shift ? 8'h7B : 8'h5B;
      8'h5B: ch = shift ? 8'h7D : 8'h5D;
      8'h5D: ch = shift ? 8'h7C : 8'h5C;
      8'h4C: ch = shift ? 8'h3A : 8'h3B;
      8'h52: ch = shift ? 8'h22 : 8'h27;
      8'h41: ch = shift ? 8'h3C : 8'h2C;
      8'h49: ch = shift ? 8'h3E : 8'h2E;
      8'h4A: ch = shift ? 8'h3F : 8'h2F;
      SC_ENTER: ch = 8'h0D;
      SC_BKSP:  ch = 8'h08;
      8'h29:    ch = 8'h20;
      default:  ch = 8'h00;
    endcase
    if (is_letter && upper) begin
      ch = ch - 8'h20;
    end
    return ch;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver.
//   clk, clrn          : system clock, async active-low reset
//   ps2_clk, ps2_data  : raw asynchronous PS/2 pins
//   rx_byte            : last good data byte
//   rx_valid           : one-cycle pulse, rx_byte holds a new good byte
//   rx_err             : one-cycle pulse, frame dropped (parity/start/stop)
module ps2_rx #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYC);

  logic [2:0]    clk_sync;
  logic [2:0]    data_sync;
  logic [9:0]    shift_reg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] idle_cnt;
  logic          fall;
  logic [10:0]   frame;
  logic          frame_ok;

  // The PS/2 clock falls once the low level has reached the middle stage
  // while the last stage still holds the old high level.
  assign fall = clk_sync[2] & ~clk_sync[1];

  // Bits arrive LSB first, so each new bit enters at the top; on the 11th
  // bit this is the complete frame with the start bit at index 0.
  assign frame    = {data_sync[2], shift_reg};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  // Synchronisers, frame shifter, bit counter and the idle timeout that
  // throws away a partial frame if the keyboard stops clocking.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      shift_reg <= '0;
      bit_cnt   <= '0;
      idle_cnt  <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[1:0], ps2_data};
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            rx_byte  <= frame[8:1];
            rx_valid <= 1'b1;
          end else begin
            rx_err <= 1'b1;
          end
        end else begin
          shift_reg <= frame[10:1];
          bit_cnt   <= bit_cnt + 4'd1;
        end
      end else if (idle_cnt != TIMEOUT_VAL) begin
        idle_cnt <= idle_cnt + TW'(1);
      end else if (bit_cnt != 4'd0) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/kbd_ascii_src.sv
// kbd_ascii_src: PS/2 keyboard to level-held ASCII source.
//   clk, clrn          : 50 MHz system clock, async active-low reset
//   ps2_clk, ps2_data  : raw PS/2 pins
//   ascii              : ASCII of the most recently pressed held key, 0 if none
//   scan_code          : last accepted mapped make code (no E0 prefix)
//   key_down           : a mapped key is held
//   shift_on, caps_on  : Shift held / Caps Lock toggle state
//   parity_err         : one-cycle pulse per dropped bad frame
//   overflow           : sticky, a code was lost because the FIFO was full
module kbd_ascii_src
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii,
  output logic [7:0] scan_code,
  output logic       key_down,
  output logic       shift_on,
  output logic       caps_on,
  output logic       parity_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_VAL = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_full;
  logic          pop_en;
  logic          push_ok;
  logic [7:0]    rd_byte;
  logic [7:0]    map_code;
  dec_state_t    state;
  logic          lshift_held;
  logic          rshift_held;
  logic          caps_held;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk      (clk),
    .clrn     (clrn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (parity_err)
  );

  // The decoder drains one byte per cycle; fullness is judged after that
  // pop so a push arriving alongside a pop into a full FIFO still lands.
  assign pop_en    = (fifo_cnt != '0);
  assign fifo_full = (fifo_cnt == DEPTH_VAL);
  assign push_ok   = rx_valid & (~fifo_full | pop_en);
  assign rd_byte   = fifo_mem[rd_ptr];
  assign map_code  = sc2ascii(rd_byte, shift_on ^ caps_on, shift_on);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= rx_byte;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_en})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (rx_valid && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // Decoder: prefix state machine plus key tracking. Shift keys are tracked
  // individually so releasing one keeps Shift active while the other is
  // held; caps_held blocks typematic repeats of Caps Lock from re-toggling.
  // Only a break of the key that currently owns ascii clears it.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      ascii       <= '0;
      scan_code   <= '0;
      key_down    <= 1'b0;
      shift_on    <= 1'b0;
      caps_on     <= 1'b0;
      lshift_held <= 1'b0;
      rshift_held <= 1'b0;
      caps_held   <= 1'b0;
    end else if (pop_en) begin
      case (state)
        ST_IDLE: begin
          if (rd_byte == SC_EXT) begin
            state <= ST_EXT;
          end else if (rd_byte == SC_BRK) begin
            state <= ST_BRK;
          end else begin
            if (rd_byte == SC_LSHIFT) begin
              lshift_held <= 1'b1;
              shift_on    <= 1'b1;
            end
            if (rd_byte == SC_RSHIFT) begin
              rshift_held <= 1'b1;
              shift_on    <= 1'b1;
            end
            if (rd_byte == SC_CAPS) begin
              caps_held <= 1'b1;
              if (!caps_held) begin
                caps_on <= ~caps_on;
              end
            end
            if (map_code != 8'h00) begin
              ascii     <= map_code;
              scan_code <= rd_byte;
              key_down  <= 1'b1;
            end
          end
        end
        ST_EXT: begin
          state <= (rd_byte == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_BRK: begin
          state <= ST_IDLE;
          if (rd_byte == SC_LSHIFT) begin
            lshift_held <= 1'b0;
            shift_on    <= rshift_held;
          end
          if (rd_byte == SC_RSHIFT) begin
            rshift_held <= 1'b0;
            shift_on    <= lshift_held;
          end
          if (rd_byte == SC_CAPS) begin
            caps_held <= 1'b0;
          end
          if (rd_byte == scan_code) begin
            ascii    <= '0;
            key_down <= 1'b0;
          end
        end
        ST_EXT_BRK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_ascii_src.sv
// tb_kbd_ascii_src: scoreboard bench for kbd_ascii_src. Stimulus sends PS/2
// frames and queues every expected change of the output tuple
// {ascii, scan_code, key_down, shift_on, caps_on}; a monitor pops and
// compares whenever the tuple changes.
module tb_kbd_ascii_src;

  localparam int HALF    = 10;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ascii;
  logic [7:0] scan_code;
  logic       key_down;
  logic       shift_on;
  logic       caps_on;
  logic       parity_err;
  logic       overflow;

  int          checks = 0;
  int          failures = 0;
  logic [18:0] exp_q[$];
  logic [18:0] obs_now;
  logic [18:0] prev_obs;
  logic [18:0] exp_obs;
  bit          mon_en = 1'b0;
  bit          lat_pending = 1'b0;
  int unsigned cyc = 0;
  int unsigned last_fall_cyc = 0;
  int          perr_cycles = 0;
  int          perr_start;

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  kbd_ascii_src #(.FIFO_DEPTH(8), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ascii      (ascii),
    .scan_code  (scan_code),
    .key_down   (key_down),
    .shift_on   (shift_on),
    .caps_on    (caps_on),
    .parity_err (parity_err),
    .overflow   (overflow)
  );

  assign obs_now = {ascii, scan_code, key_down, shift_on, caps_on};

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_obs(input logic [7:0] a, input logic [7:0] sc,
                            input logic kd, input logic sh, input logic cp);
    exp_q.push_back({a, sc, kd, sh, cp});
  endtask

  // Sends the first nbits of an 11-bit frame; bad_parity inverts the parity bit.
  task automatic applyStimulus(input logic [7:0] code, input bit bad_parity = 1'b0,
                               input int nbits = 11);
    logic [10:0] frame;
    frame = {1'b1, (~^code) ^ bad_parity, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = frame[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      if (i == 10) last_fall_cyc = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cycles(3 * HALF);
  endtask

  // Monitor: every change of the output tuple consumes one expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (parity_err) perr_cycles++;
      if (obs_now !== prev_obs) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_change actual=%h previous=%h", obs_now, prev_obs);
        end else begin
          exp_obs = exp_q.pop_front();
          checkOutput("scoreboard", {13'd0, obs_now}, {13'd0, exp_obs});
          if (lat_pending) begin
            checkOutput("latency_cycles", cyc - last_fall_cyc, 32'd5);
            lat_pending = 1'b0;
          end
        end
        prev_obs = obs_now;
      end
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clrn     = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(3);
    checkOutput("reset_ascii", {24'd0, ascii}, 32'd0);
    checkOutput("reset_scan_code", {24'd0, scan_code}, 32'd0);
    checkOutput("reset_key_down", {31'd0, key_down}, 32'd0);
    checkOutput("reset_shift_on", {31'd0, shift_on}, 32'd0);
    checkOutput("reset_caps_on", {31'd0, caps_on}, 32'd0);
    checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    clrn = 1'b1;
    wait_cycles(2);
    prev_obs = obs_now;
    mon_en   = 1'b1;

    $display("[TB] partial frame discarded by reset");
    applyStimulus(8'hFF, 1'b0, 5);
    clrn = 1'b0;
    wait_cycles(2);
    clrn = 1'b1;
    wait_cycles(2);

    $display("[TB] make/break 1C with latency check");
    lat_pending = 1'b1;
    expect_obs(8'h61, 8'h1C, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h1C);

    $display("[TB] shifted letter");
    expect_obs(8'h00, 8'h1C, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h12);
    expect_obs(8'h41, 8'h1C, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h1C, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h12);

    $display("[TB] caps lock typematic");
    expect_obs(8'h00, 8'h1C, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h58);
    applyStimulus(8'h58);
    applyStimulus(8'h58);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);
    expect_obs(8'h41, 8'h1C, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h1C, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h1C);
    expect_obs(8'h00, 8'h1C, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h58);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);

    $display("[TB] key takeover");
    expect_obs(8'h61, 8'h1C, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h1C);
    expect_obs(8'h62, 8'h32, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h32);
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h32, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h32);

    $display("[TB] bad parity then enter");
    perr_start = perr_cycles;
    applyStimulus(8'h5A, 1'b1);
    wait_cycles(5);
    checkOutput("parity_err_pulse_cycles", perr_cycles - perr_start, 32'd1);
    checkOutput("ascii_after_bad_frame", {24'd0, ascii}, 32'd0);
    expect_obs(8'h0D, 8'h5A, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h5A);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5A);

    $display("[TB] timeout of partial frame");
    applyStimulus(8'hA5, 1'b0, 6);
    wait_cycles(TIMEOUT + 100);
    expect_obs(8'h08, 8'h66, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h66);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h66, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h66);

    $display("[TB] two shifts, shifted digit, extended codes");
    expect_obs(8'h00, 8'h66, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h12);
    applyStimulus(8'h59);
    applyStimulus(8'hF0);
    applyStimulus(8'h12);
    expect_obs(8'h21, 8'h16, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h16);
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h16);
    applyStimulus(8'hF0);
    expect_obs(8'h21, 8'h16, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h59);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h16, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h16);

    $display("[TB] fifo overflow with stalled decoder");
    checkOutput("overflow_before_stall", {31'd0, overflow}, 32'd0);
    force dut.pop_en = 1'b0;
    applyStimulus(8'h1C);
    applyStimulus(8'h32);
    applyStimulus(8'h21);
    applyStimulus(8'h23);
    applyStimulus(8'h24);
    applyStimulus(8'h2B);
    applyStimulus(8'h34);
    applyStimulus(8'h33);
    applyStimulus(8'h43);
    wait_cycles(5);
    checkOutput("overflow_set", {31'd0, overflow}, 32'd1);
    expect_obs(8'h61, 8'h1C, 1'b1, 1'b0, 1'b0);
    expect_obs(8'h62, 8'h32, 1'b1, 1'b0, 1'b0);
    expect_obs(8'h63, 8'h21, 1'b1, 1'b0, 1'b0);
    expect_obs(8'h64, 8'h23, 1'b1, 1'b0, 1'b0);
    expect_obs(8'h65, 8'h24, 1'b1, 1'b0, 1'b0);
    expect_obs(8'h66, 8'h2B, 1'b1, 1'b0, 1'b0);
    expect_obs(8'h67, 8'h34, 1'b1, 1'b0, 1'b0);
    expect_obs(8'h68, 8'h33, 1'b1, 1'b0, 1'b0);
    release dut.pop_en;
    wait_cycles(20);
    applyStimulus(8'hF0);
    expect_obs(8'h00, 8'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h33);

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) wait_cycles(1);
    checkOutput("pending_expectations", exp_q.size(), 32'd0);
    checkOutput("parity_err_total_cycles", perr_cycles, 32'd1);
    checkOutput("overflow_sticky", {31'd0, overflow}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
